// File: rtl/esc_pwm_generator_pkg.sv
// Shared motor-path definitions: rate width, system clock and ESC PWM timing
// defaults, plus the generator's state encodings.
package esc_pwm_generator_pkg;

  localparam int unsigned MOTOR_RATE_BIT_WIDTH = 8;
  localparam int unsigned SYS_CLK_HZ           = 38_000_000;
  localparam int unsigned PWM_FRAME_HZ         = 400;
  localparam int unsigned PWM_PERIOD_CYCLES    = SYS_CLK_HZ / PWM_FRAME_HZ;
  localparam int unsigned PWM_MIN_PULSE_CYCLES = 38_000;
  localparam int unsigned PWM_STEP_CYCLES      = 149;
  localparam int unsigned PWM_ARM_PERIODS      = 200;
  localparam int unsigned PWM_CNT_W            = 17;

  typedef logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_rate_t;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ARMING = 2'b01;
  localparam logic [1:0] ST_ARMED  = 2'b10;

  // Only the arming and armed states put pulses on the wire.
  function automatic logic state_drives_pwm(input logic [1:0] st);
    return (st == ST_ARMING) || (st == ST_ARMED);
  endfunction

endpackage

// File: rtl/esc_pwm_generator_if.sv
// Mixer-to-ESC bundle: enable, four motor rates in; four PWM lines plus
// status out.
interface esc_pwm_generator_if;
  import esc_pwm_generator_pkg::*;

  logic        motor_enable;
  motor_rate_t motor_1_rate;
  motor_rate_t motor_2_rate;
  motor_rate_t motor_3_rate;
  motor_rate_t motor_4_rate;
  logic        pwm_1;
  logic        pwm_2;
  logic        pwm_3;
  logic        pwm_4;
  logic        armed;
  logic        frame_start;

  modport master (
    output motor_enable, motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
    input  pwm_1, pwm_2, pwm_3, pwm_4, armed, frame_start
  );

  modport slave (
    input  motor_enable, motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
    output pwm_1, pwm_2, pwm_3, pwm_4, armed, frame_start
  );

endinterface

// File: rtl/esc_pwm_generator_pwm_channel.sv
// One ESC output: frame-boundary shadow of the rate, pulse-width arithmetic
// and the registered compare against the frame counter.
module esc_pwm_generator_pwm_channel
  import esc_pwm_generator_pkg::*;
#(
  parameter int unsigned CNT_W            = PWM_CNT_W,
  parameter int unsigned MIN_PULSE_CYCLES = PWM_MIN_PULSE_CYCLES,
  parameter int unsigned STEP_CYCLES      = PWM_STEP_CYCLES
) (
  input  logic             sys_clk,
  input  logic             resetn,
  input  logic [CNT_W-1:0] cnt_next_i,
  input  logic             boundary_i,
  input  logic             force_min_i,
  input  logic             force_off_i,
  input  motor_rate_t      rate_i,
  output logic             pwm_o
);

  motor_rate_t      shadow_q;
  motor_rate_t      shadow_d;
  logic [CNT_W-1:0] width_s;
  logic             pwm_q;
  logic             pwm_d;

  // Shadow, width and compare all look at next-cycle values so the pulse
  // rises on the very edge that starts the frame.
  always_comb begin
    shadow_d = shadow_q;
    width_s  = CNT_W'(MIN_PULSE_CYCLES);
    pwm_d    = 1'b0;
    if (boundary_i) begin
      shadow_d = rate_i;
    end else begin
      shadow_d = shadow_q;
    end
    if (force_min_i) begin
      width_s = CNT_W'(MIN_PULSE_CYCLES);
    end else begin
      width_s = CNT_W'(MIN_PULSE_CYCLES) + CNT_W'(shadow_d) * CNT_W'(STEP_CYCLES);
    end
    if (force_off_i) begin
      pwm_d = 1'b0;
    end else begin
      pwm_d = (cnt_next_i < width_s);
    end
  end

  // Shadow rate and output flop.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/esc_pwm_generator.sv
// Four-channel ESC PWM generator: free-running frame counter, arming state
// machine, and four channels that only take new rates at frame boundaries.
module esc_pwm_generator
  import esc_pwm_generator_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES    = PWM_PERIOD_CYCLES,
  parameter int unsigned MIN_PULSE_CYCLES = PWM_MIN_PULSE_CYCLES,
  parameter int unsigned STEP_CYCLES      = PWM_STEP_CYCLES,
  parameter int unsigned ARM_PERIODS      = PWM_ARM_PERIODS,
  parameter int unsigned CNT_W            = PWM_CNT_W
) (
  input  logic                 sys_clk,
  input  logic                 resetn,
  esc_pwm_generator_if.slave   esc_bus
);

  localparam int unsigned ARM_W = $clog2(ARM_PERIODS + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             boundary_s;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [ARM_W-1:0] arm_cnt_q;
  logic [ARM_W-1:0] arm_cnt_d;
  logic [ARM_W-1:0] arm_cnt_inc_s;
  logic             frame_start_q;
  logic             armed_q;
  logic             force_min_s;
  logic             force_off_s;
  motor_rate_t      rate_s [4];
  logic [3:0]       pwm_s;

  // Frame counter wraps at PERIOD_CYCLES-1 regardless of state.
  always_comb begin
    boundary_s = (cnt_q == CNT_W'(PERIOD_CYCLES - 1));
    if (boundary_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Arming state machine; legal states move only on a boundary, an illegal
  // encoding falls straight back to IDLE.
  always_comb begin
    state_d       = state_q;
    arm_cnt_d     = arm_cnt_q;
    arm_cnt_inc_s = arm_cnt_q + ARM_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (boundary_s && esc_bus.motor_enable) begin
          state_d   = ST_ARMING;
          arm_cnt_d = '0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ARMING: begin
        if (!boundary_s) begin
          state_d   = ST_ARMING;
        end else if (!esc_bus.motor_enable) begin
          state_d   = ST_IDLE;
          arm_cnt_d = '0;
        end else if (arm_cnt_inc_s == ARM_W'(ARM_PERIODS)) begin
          state_d   = ST_ARMED;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_inc_s;
        end
      end
      ST_ARMED: begin
        if (boundary_s && !esc_bus.motor_enable) begin
          state_d   = ST_IDLE;
        end else begin
          state_d   = ST_ARMED;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arm_cnt_d = '0;
      end
    endcase
    force_min_s = (state_d == ST_ARMING);
    force_off_s = !state_drives_pwm(state_d);
  end

  // Counter, state and status flops.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q         <= '0;
      state_q       <= ST_IDLE;
      arm_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      frame_start_q <= boundary_s;
      armed_q       <= (state_d == ST_ARMED);
    end
  end

  assign rate_s[0] = esc_bus.motor_1_rate;
  assign rate_s[1] = esc_bus.motor_2_rate;
  assign rate_s[2] = esc_bus.motor_3_rate;
  assign rate_s[3] = esc_bus.motor_4_rate;

  for (genvar ch = 0; ch < 4; ch++) begin : g_chan
    esc_pwm_generator_pwm_channel #(
      .CNT_W            (CNT_W),
      .MIN_PULSE_CYCLES (MIN_PULSE_CYCLES),
      .STEP_CYCLES      (STEP_CYCLES)
    ) u_chan (
      .sys_clk     (sys_clk),
      .resetn      (resetn),
      .cnt_next_i  (cnt_d),
      .boundary_i  (boundary_s),
      .force_min_i (force_min_s),
      .force_off_i (force_off_s),
      .rate_i      (rate_s[ch]),
      .pwm_o       (pwm_s[ch])
    );
  end

  assign esc_bus.pwm_1       = pwm_s[0];
  assign esc_bus.pwm_2       = pwm_s[1];
  assign esc_bus.pwm_3       = pwm_s[2];
  assign esc_bus.pwm_4       = pwm_s[3];
  assign esc_bus.armed       = armed_q;
  assign esc_bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_esc_pwm_generator.sv
// Directed bench for esc_pwm_generator using a shortened frame
// (600 cycles, 200-cycle minimum, 1 cycle per LSB, 4 arming frames).
module tb_esc_pwm_generator;

  localparam int P    = 600;
  localparam int MINP = 200;
  localparam int STEP = 1;
  localparam int ARM  = 4;
  localparam int CW   = 10;

  logic sys_clk = 1'b0;
  logic resetn;
  bit   synced = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  esc_pwm_generator_if bus ();

  esc_pwm_generator #(
    .PERIOD_CYCLES    (P),
    .MIN_PULSE_CYCLES (MINP),
    .STEP_CYCLES      (STEP),
    .ARM_PERIODS      (ARM),
    .CNT_W            (CW)
  ) dut (
    .sys_clk (sys_clk),
    .resetn  (resetn),
    .esc_bus (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_vec(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pwm_vec();
    return {bus.pwm_4, bus.pwm_3, bus.pwm_2, bus.pwm_1};
  endfunction

  // Waits for the next frame_start, expecting no pulse on the way.
  task automatic idle_frame(input string tag);
    int n  = 0;
    int hi = 0;
    while (n < 2 * P) begin
      @(negedge sys_clk);
      n++;
      if (bus.frame_start) break;
      if (pwm_vec() != 4'b0000) hi++;
    end
    check_vec({tag, "_len"}, n, P);
    check_vec({tag, "_pwm"}, hi, 0);
    check_vec({tag, "_armed"}, int'(bus.armed), 0);
    synced = 1'b1;
  endtask

  // Measures one frame's high times; applies an action at counter act_at.
  task automatic run_frame(input string tag, input int act_at, input int act_kind,
                           input int e1, input int e2, input int e3, input int e4,
                           input int earmed);
    int n = 0;
    int extra = 0;
    int hi [4];
    logic [3:0] pv;
    hi = '{0, 0, 0, 0};
    if (synced) begin
      synced = 1'b0;
      n = 1;
    end else begin
      do begin
        @(negedge sys_clk);
        n++;
      end while (!bus.frame_start && n < 2 * P);
    end
    check_vec({tag, "_gap"}, n, 1);
    check_vec({tag, "_armed"}, int'(bus.armed), earmed);
    for (int i = 0; i < P; i++) begin
      if (i > 0) begin
        @(negedge sys_clk);
        if (bus.frame_start) extra++;
      end
      pv = pwm_vec();
      for (int c = 0; c < 4; c++) if (pv[c]) hi[c]++;
      if (i == act_at) begin
        case (act_kind)
          1: bus.motor_1_rate = 8'd255;
          2: bus.motor_enable = 1'b0;
          3: bus.motor_enable = 1'b1;
          4: begin
            bus.motor_1_rate = 8'd0;
            bus.motor_2_rate = 8'd255;
            bus.motor_3_rate = 8'd1;
            bus.motor_4_rate = 8'd128;
          end
          5: begin
            check_vec({tag, "_pre_rst_pwm1"}, int'(bus.pwm_1), 1);
            resetn = 1'b0;
            #1;
            check_vec({tag, "_rst_pwm"}, int'(pwm_vec()), 0);
            check_vec({tag, "_rst_armed"}, int'(bus.armed), 0);
            return;
          end
          default: ;
        endcase
      end
    end
    check_vec({tag, "_w1"}, hi[0], e1);
    check_vec({tag, "_w2"}, hi[1], e2);
    check_vec({tag, "_w3"}, hi[2], e3);
    check_vec({tag, "_w4"}, hi[3], e4);
    check_vec({tag, "_period"}, extra, 0);
  endtask

  initial begin
    resetn           = 1'b0;
    bus.motor_enable = 1'b0;
    bus.motor_1_rate = 8'h80;
    bus.motor_2_rate = 8'h80;
    bus.motor_3_rate = 8'h80;
    bus.motor_4_rate = 8'h80;
    repeat (3) @(negedge sys_clk);
    check_vec("reset_pwm", int'(pwm_vec()), 0);
    check_vec("reset_armed", int'(bus.armed), 0);
    check_vec("reset_fs", int'(bus.frame_start), 0);
    resetn           = 1'b1;
    bus.motor_enable = 1'b1;
    idle_frame("idle0");

    for (int f = 1; f <= ARM; f++)
      run_frame($sformatf("arming%0d", f), -1, 0, 200, 200, 200, 200, 0);
    // Rates written mid-frame only show up in the following frame.
    run_frame("armed1", 10, 4, 328, 328, 328, 328, 1);
    run_frame("rates", 100, 1, 200, 455, 201, 328, 1);
    run_frame("rate_chg", 50, 2, 455, 455, 201, 328, 1);
    run_frame("disabled", 300, 3, 0, 0, 0, 0, 0);
    for (int f = 1; f <= ARM; f++)
      run_frame($sformatf("rearm%0d", f), -1, 0, 200, 200, 200, 200, 0);
    run_frame("rearmed_rst", 30, 5, 455, 455, 201, 328, 1);

    repeat (3) @(negedge sys_clk);
    resetn = 1'b1;
    idle_frame("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
